// File: rtl/mem_bus_master_if.sv
// Core request/response channels and memory req/ack handshake for mem_bus_master.
interface mem_bus_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              core_req_valid;
  logic              core_req_ready;
  logic              core_req_we;
  logic [ADDR_W-1:0] core_req_addr;
  logic [DATA_W-1:0] core_req_wdata;
  logic              core_rsp_valid;
  logic              core_rsp_ready;
  logic [DATA_W-1:0] core_rsp_data;
  logic              core_rsp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  core_req_valid, core_req_we, core_req_addr, core_req_wdata,
    input  core_rsp_ready, mem_ack, mem_rdata,
    output core_req_ready, core_rsp_valid, core_rsp_data, core_rsp_err,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output core_req_valid, core_req_we, core_req_addr, core_req_wdata,
    output core_rsp_ready, mem_ack, mem_rdata,
    input  core_req_ready, core_rsp_valid, core_rsp_data, core_rsp_err,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_bus_master.sv
// Single-access memory initiator with alignment check and ack timeout.
// Optional statistics counters enabled by defining MEM_BUS_MASTER_STATS_EN.
module mem_bus_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input logic Clock,
  input logic Reset,
  mem_bus_master_if.master bus
`ifdef MEM_BUS_MASTER_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_xfers,
  output logic [CNT_W-1:0] stat_errs,
  output logic [CNT_W-1:0] stat_wait
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  assign bus.core_req_ready = (state_q == IDLE);
  assign bus.core_rsp_valid = (state_q == RESP);
  assign bus.core_rsp_data  = rsp_data_q;
  assign bus.core_rsp_err   = rsp_err_q;
  assign bus.mem_req        = mem_req_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wdata      = mem_wdata_q;

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path infers a latch.
    state_d     = state_q;
    timer_d     = timer_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (bus.core_req_valid) begin
          rsp_data_d = '0;
          if (bus.core_req_addr[1:0] != 2'b00) begin
            // Misaligned: answer with an error without touching memory.
            state_d   = RESP;
            rsp_err_d = 1'b1;
          end else begin
            state_d     = REQ;
            rsp_err_d   = 1'b0;
            timer_d     = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.core_req_we;
            mem_addr_d  = bus.core_req_addr;
            mem_wdata_d = bus.core_req_wdata;
          end
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          state_d    = RESP;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          rsp_err_d  = 1'b0;
          rsp_data_d = mem_we_q ? '0 : bus.mem_rdata;
        end else if (timer_q == TMR_LAST) begin
          state_d    = RESP;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.core_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      timer_q     <= timer_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef MEM_BUS_MASTER_STATS_EN
  logic rsp_hs;
  assign rsp_hs = (state_q == RESP) && bus.core_rsp_ready;

  // Saturating event counters.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stat_xfers <= '0;
      stat_errs  <= '0;
      stat_wait  <= '0;
    end else begin
      if (rsp_hs && !(&stat_xfers))             stat_xfers <= stat_xfers + 1'b1;
      if (rsp_hs && rsp_err_q && !(&stat_errs)) stat_errs  <= stat_errs + 1'b1;
      if ((state_q == REQ) && !(&stat_wait))    stat_wait  <= stat_wait + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed plus randomized bench for mem_bus_master; the bench plays the memory.
module tb_mem_bus_master;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  mem_bus_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_BUS_MASTER_STATS_EN
  logic [CNT_W-1:0] stat_xfers, stat_errs, stat_wait;
`endif

  mem_bus_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
`ifdef MEM_BUS_MASTER_STATS_EN
    ,
    .stat_xfers (stat_xfers),
    .stat_errs  (stat_errs),
    .stat_wait  (stat_wait)
`endif
  );

  int n_vec  = 0;
  int n_miss = 0;
  int m_xfers = 0, m_errs = 0, m_wait = 0;
  logic [31:0] mem_model [logic [31:0]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'hC0DE_5A5A;
  endfunction

  // One complete access: accept, memory phase, held response, handshake.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_dly, input int rsp_dly);
    bit mis, tout, got;
    int exp_req, req_n, lat;
    logic [31:0] exp_data;
    logic exp_err;
    mis      = (addr[1:0] != 2'b00);
    tout     = !mis && (ack_dly >= TIMEOUT);
    exp_err  = mis || tout;
    exp_req  = mis ? 0 : (tout ? TIMEOUT : ack_dly + 1);
    exp_data = (exp_err || we) ? 32'h0 : rd_val(addr);

    @(negedge Clock);
    check("req_ready_idle", bus.core_req_ready, 1);
    bus.core_req_valid = 1'b1;
    bus.core_req_we    = we;
    bus.core_req_addr  = addr;
    bus.core_req_wdata = wdata;
    @(negedge Clock);
    bus.core_req_valid = 1'b0;

    req_n = 0; got = 0; lat = 0;
    for (int c = 0; c < 64; c++) begin
      bus.mem_ack = 1'b0;
      if (bus.core_rsp_valid) begin got = 1; lat = c; break; end
      if (bus.mem_req) begin
        req_n++;
        check("mem_addr", bus.mem_addr, addr);
        check("mem_we", bus.mem_we, we);
        if (we) check("mem_wdata", bus.mem_wdata, wdata);
        if (!tout && req_n == ack_dly + 1) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rd_val(addr);
          if (we) mem_model[addr] = wdata;
        end else begin
          bus.mem_rdata = $urandom;
        end
      end
      @(negedge Clock);
    end
    bus.mem_ack = 1'b0;
    check("rsp_arrived", got, 1);
    check("rsp_latency", lat, exp_req);
    check("mem_req_cycles", req_n, exp_req);
    check("mem_req_low_rsp", bus.mem_req, 0);
    check("mem_we_low_rsp", bus.mem_we, 0);
    check("rsp_data", bus.core_rsp_data, exp_data);
    check("rsp_err", bus.core_rsp_err, exp_err);
    check("req_ready_rsp", bus.core_req_ready, 0);

    for (int k = 0; k < rsp_dly; k++) begin
      bus.core_req_valid = $urandom_range(0, 1);
      bus.core_req_addr  = {$urandom_range(0, 255), 2'b00};
      bus.mem_ack        = tout && (k == 2);
      @(negedge Clock);
      check("hold_valid", bus.core_rsp_valid, 1);
      check("hold_data", bus.core_rsp_data, exp_data);
      check("hold_err", bus.core_rsp_err, exp_err);
      check("hold_ready", bus.core_req_ready, 0);
      check("hold_mem_req", bus.mem_req, 0);
    end
    bus.core_req_valid = 1'b0;
    bus.mem_ack        = 1'b0;
    bus.core_rsp_ready = 1'b1;
    @(negedge Clock);
    bus.core_rsp_ready = 1'b0;
    check("post_hs_valid", bus.core_rsp_valid, 0);
    check("post_hs_ready", bus.core_req_ready, 1);
    check("post_hs_mem_req", bus.mem_req, 0);
    m_xfers++;
    if (exp_err) m_errs++;
    m_wait += exp_req;
  endtask

  initial begin
    bus.core_req_valid = 1'b0;
    bus.core_req_we    = 1'b0;
    bus.core_req_addr  = '0;
    bus.core_req_wdata = '0;
    bus.core_rsp_ready = 1'b0;
    bus.mem_ack        = 1'b0;
    bus.mem_rdata      = '0;
    mem_model[32'h10]  = 32'hDEAD_BEEF;

    #12;
    check("rst_req_ready", bus.core_req_ready, 1);
    check("rst_rsp_valid", bus.core_rsp_valid, 0);
    check("rst_rsp_err", bus.core_rsp_err, 0);
    check("rst_rsp_data", bus.core_rsp_data, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    @(negedge Clock);
    Reset = 1'b0;

    do_txn(1'b0, 32'h10, 32'h0, 2, 0);             // read, ack after two cycles
    do_txn(1'b1, 32'h20, 32'h1234_5678, 0, 0);     // store, immediate ack
    do_txn(1'b0, 32'h22, 32'h0, 0, 0);             // misaligned read
    do_txn(1'b0, 32'h30, 32'h0, 99, 5);            // timeout plus late ack
    do_txn(1'b0, 32'h20, 32'h0, 1, 5);             // backpressure, reads stored word

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int dly, rdly;
      a    = {24'h0, 2'b0, 4'($urandom_range(4, 15)), 2'b00};
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      dly  = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(0, 5);
      rdly = (dly >= TIMEOUT) ? 5 : $urandom_range(0, 3);
      do_txn(1'($urandom_range(0, 1)), a, $urandom, dly, rdly);
    end

`ifdef MEM_BUS_MASTER_STATS_EN
    check("stat_xfers", stat_xfers, m_xfers);
    check("stat_errs", stat_errs, m_errs);
    check("stat_wait", stat_wait, m_wait);
`endif

    // Reset in the middle of a memory access.
    @(negedge Clock);
    bus.core_req_valid = 1'b1;
    bus.core_req_we    = 1'b1;
    bus.core_req_addr  = 32'h40;
    bus.core_req_wdata = 32'hA5A5_A5A5;
    @(negedge Clock);
    bus.core_req_valid = 1'b0;
    check("mid_mem_req", bus.mem_req, 1);
    @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    check("async_mem_req", bus.mem_req, 0);
    check("async_mem_we", bus.mem_we, 0);
    check("async_mem_addr", bus.mem_addr, 0);
    check("async_rsp_valid", bus.core_rsp_valid, 0);
    check("async_req_ready", bus.core_req_ready, 1);
    @(negedge Clock);
    Reset = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    @(negedge Clock);
    bus.mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      check("post_rst_rsp_valid", bus.core_rsp_valid, 0);
      check("post_rst_mem_req", bus.mem_req, 0);
    end
`ifdef MEM_BUS_MASTER_STATS_EN
    check("stat_xfers_rst", stat_xfers, 0);
    check("stat_wait_rst", stat_wait, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
